pattern_frame_ctrl: RTL and testbench

//  Sequencer in front of pattern_detection. Takes parallel words from an upstream valid/ready source and

---
 rtl/pattern_pkg.sv | 18 +
 rtl/pattern_ser.sv | 44 ++++
 rtl/pattern_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_pattern_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encoding and counter sizing for the pattern frame sequencer
package pattern_pkg;

  typedef logic [2:0] pfc_state_t;

  localparam pfc_state_t ST_IDLE   = 3'd0;
  localparam pfc_state_t ST_CLEAR  = 3'd1;
  localparam pfc_state_t ST_LOAD   = 3'd2;
  localparam pfc_state_t ST_SHIFT  = 3'd3;
  localparam pfc_state_t ST_DRAIN  = 3'd4;
  localparam pfc_state_t ST_REPORT = 3'd5;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int pfc_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_ser.sv
// rtl/pattern_ser.sv - MSB-first word serializer with bit position flags
module pattern_ser
  import pattern_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              clr_i,
  output logic              bit_o,
  output logic              last_bit_o,
  output logic              near_last_o
);

  localparam int BIT_W = pfc_cnt_w(WORD_W);

  logic [WORD_W-1:0] sr;
  logic [BIT_W-1:0]  bit_cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr_i) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load_i) begin
      sr      <= load_data_i;
      bit_cnt <= '0;
    end else if (shift_i) begin
      sr      <= sr << 1;
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // The MSB of the register is the bit currently on the wire, so the output is a flop.
  assign bit_o       = sr[WORD_W-1];
  assign last_bit_o  = (bit_cnt == BIT_W'(WORD_W-1));
  assign near_last_o = (WORD_W >= 2) && (bit_cnt == BIT_W'(WORD_W-2));

endmodule

// File: rtl/pattern_frame_ctrl.sv
// rtl/pattern_frame_ctrl.sv - frames words onto the pattern detector and reports per-frame match counts
module pattern_frame_ctrl
  import pattern_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 8,
  parameter int DET_LAT = 1,
  parameter int CLR_CYC = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              det_reset_o,
  output logic              det_data_o,
  input  logic              det_match_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [CNT_W-1:0]  r_count_o,
  output logic              r_ovf_o,
  output logic              r_err_o
);

  localparam int CLR_W = pfc_cnt_w(CLR_CYC);
  localparam int LAT_W = pfc_cnt_w(DET_LAT);

  pfc_state_t       state, state_n;
  logic [CLR_W-1:0] clr_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             last_q, last_n;
  logic [CNT_W-1:0] match_cnt, match_cnt_n;
  logic             ovf_q, ovf_n, err_q, err_n;
  logic             ser_load, ser_shift, ser_clr;
  logic             ser_last_bit, ser_near_last, next_is_final;
  logic             s_hs;

  assign s_hs = s_valid_i & s_ready_o;

  pattern_ser #(.WORD_W(WORD_W)) u_ser (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (ser_load),
    .load_data_i (s_data_i),
    .shift_i     (ser_shift),
    .clr_i       (ser_clr),
    .bit_o       (det_data_o),
    .last_bit_o  (ser_last_bit),
    .near_last_o (ser_near_last)
  );

  always_comb begin
    state_n   = state;
    last_n    = last_q;
    err_n     = err_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_clr   = 1'b0;
    case (state)
      ST_IDLE:   if (s_valid_i) state_n = ST_CLEAR;
      ST_CLEAR:  if (clr_cnt == CLR_W'(CLR_CYC-1)) state_n = ST_LOAD;
      ST_LOAD: begin
        if (s_hs) begin
          ser_load = 1'b1;
          last_n   = s_last_i;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!ser_last_bit) begin
          ser_shift = 1'b1;
        end else if (last_q) begin
          ser_clr = 1'b1;
          state_n = ST_DRAIN;
        end else if (s_hs) begin
          // Back-to-back reload keeps the bit stream free of bubbles.
          ser_load = 1'b1;
          last_n   = s_last_i;
        end else begin
          ser_clr = 1'b1;
          err_n   = 1'b1;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (lat_cnt == LAT_W'(DET_LAT-1)) state_n = ST_REPORT;
      ST_REPORT: if (r_ready_i) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    match_cnt_n = match_cnt;
    ovf_n       = ovf_q;
    if (state == ST_CLEAR) begin
      match_cnt_n = '0;
      ovf_n       = 1'b0;
    end else if ((state == ST_SHIFT || state == ST_DRAIN) && det_match_i) begin
      if (&match_cnt) ovf_n = 1'b1;
      else            match_cnt_n = match_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign next_is_final = ser_load ? (WORD_W == 1) : (ser_shift & ser_near_last);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      lat_cnt     <= '0;
      last_q      <= 1'b0;
      match_cnt   <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      s_ready_o   <= 1'b0;
      det_reset_o <= 1'b0;
      r_valid_o   <= 1'b0;
      r_count_o   <= '0;
      r_ovf_o     <= 1'b0;
      r_err_o     <= 1'b0;
    end else begin
      state       <= state_n;
      clr_cnt     <= (state == ST_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      lat_cnt     <= (state == ST_DRAIN) ? lat_cnt + LAT_W'(1) : '0;
      last_q      <= last_n;
      match_cnt   <= match_cnt_n;
      ovf_q       <= ovf_n;
      err_q       <= (state == ST_CLEAR) ? 1'b0 : err_n;
      s_ready_o   <= (state_n == ST_LOAD) ||
                     ((state_n == ST_SHIFT) && next_is_final && !last_n);
      det_reset_o <= !((state_n == ST_CLEAR) || (state_n == ST_LOAD));
      r_valid_o   <= (state_n == ST_REPORT);
      if (state == ST_DRAIN && state_n == ST_REPORT) begin
        r_count_o <= match_cnt_n;
        r_ovf_o   <= ovf_n;
        r_err_o   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_pattern_frame_ctrl.sv
// tb/tb_pattern_frame_ctrl.sv - scoreboard bench for pattern_frame_ctrl with a 1011 detector model
module tb_pattern_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       r_ready = 1'b1;

  logic       s_ready0, det_reset0, det_data0, r_valid0, r_ovf0, r_err0;
  logic       det_match0 = 1'b0;
  logic [7:0] r_count0;
  logic       s_ready1, det_reset1, det_data1, r_valid1, r_ovf1, r_err1;
  logic       det_match1 = 1'b0;
  logic [1:0] r_count1;
  logic [2:0] hist0 = 3'b000;
  logic [2:0] hist1 = 3'b000;

  typedef struct {
    int count;
    int ovf;
    int err;
  } res_t;

  res_t sb0[$];
  res_t sb1[$];
  logic exp_bits[$];
  int   checks = 0;
  int   errors = 0;
  int   mid_ready = 0;

  always #5 clk = ~clk;

  pattern_frame_ctrl #(.WORD_W(8), .CNT_W(8), .DET_LAT(1), .CLR_CYC(2)) dut0 (
    .clk_i(clk), .reset_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready0),
    .s_data_i(s_data), .s_last_i(s_last), .det_reset_o(det_reset0), .det_data_o(det_data0),
    .det_match_i(det_match0), .r_valid_o(r_valid0), .r_ready_i(r_ready),
    .r_count_o(r_count0), .r_ovf_o(r_ovf0), .r_err_o(r_err0)
  );

  pattern_frame_ctrl #(.WORD_W(8), .CNT_W(2), .DET_LAT(1), .CLR_CYC(2)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready1),
    .s_data_i(s_data), .s_last_i(s_last), .det_reset_o(det_reset1), .det_data_o(det_data1),
    .det_match_i(det_match1), .r_valid_o(r_valid1), .r_ready_i(r_ready),
    .r_count_o(r_count1), .r_ovf_o(r_ovf1), .r_err_o(r_err1)
  );

  // Overlapping 1011 detectors: pulse one cycle after the fourth bit.
  always @(posedge clk) begin
    if (!det_reset0) begin
      hist0      <= 3'b000;
      det_match0 <= 1'b0;
    end else begin
      hist0      <= {hist0[1:0], det_data0};
      det_match0 <= ({hist0, det_data0} == 4'b1011);
    end
    if (!det_reset1) begin
      hist1      <= 3'b000;
      det_match1 <= 1'b0;
    end else begin
      hist1      <= {hist1[1:0], det_data1};
      det_match1 <= ({hist1, det_data1} == 4'b1011);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int m, input int err);
    res_t e;
    e.count = (m > 255) ? 255 : m;
    e.ovf   = (m > 255) ? 1 : 0;
    e.err   = err;
    sb0.push_back(e);
    e.count = (m > 3) ? 3 : m;
    e.ovf   = (m > 3) ? 1 : 0;
    sb1.push_back(e);
  endtask

  // Bit stream: every accepted word must appear MSB-first starting the next cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_bits.size() > 0) begin
        check_eq("det_data", det_data0, exp_bits.pop_front());
        check_eq("det_reset_shift", det_reset0, 1);
        check_eq("det_data_dut1", det_data1, det_data0);
      end
      if (s_valid && s_ready0)
        for (int i = 7; i >= 0; i--) exp_bits.push_back(s_data[i]);
      if (s_ready0 && det_reset0) mid_ready++;
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && r_valid0 && r_ready) begin
      if (sb0.size() == 0) check_eq("sb0_unexpected", 1, 0);
      else begin
        e = sb0.pop_front();
        check_eq("r_count0", r_count0, e.count);
        check_eq("r_ovf0", r_ovf0, e.ovf);
        check_eq("r_err0", r_err0, e.err);
      end
    end
    if (rst_n && r_valid1 && r_ready) begin
      if (sb1.size() == 0) check_eq("sb1_unexpected", 1, 0);
      else begin
        e = sb1.pop_front();
        check_eq("r_count1", r_count1, e.count);
        check_eq("r_ovf1", r_ovf1, e.ovf);
        check_eq("r_err1", r_err1, e.err);
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready0) check_eq("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results();
    int n = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("results_drained", sb0.size() + sb1.size(), 0);
    check_eq("bits_drained", exp_bits.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, s_ready0, 0);
    check_eq({tag, "_det_reset"}, det_reset0, 0);
    check_eq({tag, "_det_data"}, det_data0, 0);
    check_eq({tag, "_r_valid"}, r_valid0, 0);
    check_eq({tag, "_r_count"}, r_count0, 0);
    check_eq({tag, "_r_ovf"}, r_ovf0, 0);
    check_eq({tag, "_r_err"}, r_err0, 0);
    check_eq({tag, "_dut1_det_reset"}, det_reset1, 0);
    check_eq({tag, "_dut1_r_valid"}, r_valid1, 0);
  endtask

  initial begin
    int n;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_det_reset", det_reset0, 1);
    check_eq("idle_s_ready", s_ready0, 0);

    // Single last word.
    push_exp(2, 0);
    mid_ready = 0;
    send_word(8'hB6, 1'b1);
    s_valid = 1'b0;
    wait_results();
    check_eq("mid_ready_single", mid_ready, 0);

    // Two words, valid held high: gap-free, one mid-frame ready.
    push_exp(2, 0);
    mid_ready = 0;
    send_word(8'h0B, 1'b0);
    send_word(8'h0B, 1'b1);
    s_valid = 1'b0;
    wait_results();
    check_eq("mid_ready_pair", mid_ready, 1);

    // Underrun after a non-last word.
    push_exp(2, 1);
    send_word(8'hBB, 1'b0);
    s_valid = 1'b0;
    wait_results();
    check_eq("underrun_idle_r_valid", r_valid0, 0);
    check_eq("underrun_idle_det_reset", det_reset0, 1);
    check_eq("underrun_hold_err", r_err0, 1);
    check_eq("underrun_hold_count", r_count0, 2);

    // Result held while r_ready is low.
    r_ready = 1'b0;
    push_exp(2, 0);
    send_word(8'hB6, 1'b1);
    s_valid = 1'b0;
    n = 0;
    while (!r_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_r_valid_seen", r_valid0, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_r_valid", r_valid0, 1);
      check_eq("hold_r_count", r_count0, sb0[0].count);
      check_eq("hold_r_err", r_err0, sb0[0].err);
      check_eq("hold_s_ready", s_ready0, 0);
    end
    @(posedge clk);
    #1 r_ready = 1'b1;
    wait_results();

    // Six matches: saturates the 2-bit counter.
    push_exp(6, 0);
    send_word(8'hBB, 1'b0);
    send_word(8'hBB, 1'b0);
    send_word(8'hBB, 1'b1);
    s_valid = 1'b0;
    wait_results();

    // Cross-word match and an empty frame.
    push_exp(4, 0);
    send_word(8'h2D, 1'b0);
    send_word(8'hB6, 1'b1);
    s_valid = 1'b0;
    wait_results();
    push_exp(0, 0);
    send_word(8'hFF, 1'b1);
    s_valid = 1'b0;
    wait_results();

    // Asynchronous reset in the middle of a word.
    send_word(8'hB6, 1'b1);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    exp_bits.delete();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(2, 0);
    send_word(8'hB6, 1'b1);
    s_valid = 1'b0;
    wait_results();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
